// File: rtl/rect_intp_pkg.sv
// Shared constants and width helpers for the rectification interpolation buffers.
package rect_intp_pkg;
  localparam int W_DEF = 28;
  localparam int D_DEF = 2;

  // Occupancy runs 0..2^d inclusive, so it needs one bit more than a pointer.
  function automatic int cnt_w(input int d);
    return d + 1;
  endfunction
endpackage

// File: rtl/rect_intp_sfifo_if.sv
// Write/read handshake, data and status bundle of one interpolation-lane FIFO.
interface rect_intp_sfifo_if #(
  parameter int W = 28,
  parameter int D = 2
);
  logic         fifo_wr;
  logic [W-1:0] fifo_din;
  logic         fifo_rd;
  logic [W-1:0] fifo_dout;
  logic         dout_vld;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [D:0]   count;
  logic         err_clr;
  logic         ovf;
  logic         udf;

  modport master (
    output fifo_wr, fifo_din, fifo_rd, err_clr,
    input  fifo_dout, dout_vld, full, empty, almost_full, almost_empty, count, ovf, udf
  );
  modport slave (
    input  fifo_wr, fifo_din, fifo_rd, err_clr,
    output fifo_dout, dout_vld, full, empty, almost_full, almost_empty, count, ovf, udf
  );
endinterface

// File: rtl/rect_intp_sfifo_ram.sv
// DD x W register array: one synchronous write port, one asynchronous read port, no reset.
module rect_intp_sfifo_ram #(
  parameter int W = 28,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         we,
  input  logic [D-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [D-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [(1<<D)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/rect_intp_sfifo.sv
// Synchronous FIFO between rectification address generator and bilinear interpolator;
// FWFT or registered-read output chosen at elaboration.
module rect_intp_sfifo
  import rect_intp_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int D      = D_DEF,
  parameter bit FWFT   = 1'b1,
  parameter int AF_LVL = (1 << D) - 1,
  parameter int AE_LVL = 1
) (
  input logic               clk,
  input logic               rst,
  rect_intp_sfifo_if.slave  f
);
  localparam int CW = cnt_w(D);
  localparam int DD = 1 << D;
  localparam logic [CW-1:0] DD_C = CW'(DD);

  logic [D-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf_q, udf_q;
  logic          empty_c, full_c, rd_acc, wr_acc;
  logic [W-1:0]  rdata;

  // Every flag derives from the registered count only.
  assign empty_c = (cnt == '0);
  assign full_c  = (cnt == DD_C);
  assign rd_acc  = f.fifo_rd & ~empty_c;
  // A write into a full FIFO rides on a same-cycle accepted read.
  assign wr_acc  = f.fifo_wr & (~full_c | rd_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(wr_acc) - CW'(rd_acc);
      // A fresh error beats a concurrent clear.
      if (f.fifo_wr & ~wr_acc)  ovf_q <= 1'b1;
      else if (f.err_clr)       ovf_q <= 1'b0;
      if (f.fifo_rd & ~rd_acc)  udf_q <= 1'b1;
      else if (f.err_clr)       udf_q <= 1'b0;
    end
  end

  rect_intp_sfifo_ram #(.W(W), .D(D)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (f.fifo_din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  generate
    if (FWFT) begin : g_fwft
      assign f.fifo_dout = empty_c ? '0 : rdata;
      assign f.dout_vld  = ~empty_c;
    end else begin : g_reg
      logic [W-1:0] dout_q;
      logic         vld_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          vld_q <= rd_acc;
          if (rd_acc) dout_q <= rdata;
        end
      end
      assign f.fifo_dout = dout_q;
      assign f.dout_vld  = vld_q;
    end
  endgenerate

  assign f.count        = cnt;
  assign f.empty        = empty_c;
  assign f.full         = full_c;
  assign f.almost_full  = (int'(cnt) >= AF_LVL);
  assign f.almost_empty = (int'(cnt) <= AE_LVL);
  assign f.ovf          = ovf_q;
  assign f.udf          = udf_q;
endmodule

// File: tb/tb_rect_intp_sfifo.sv
// Drives an FWFT and a registered-read instance with identical stimulus and checks both
// against a queue-based model of the FIFO.
module tb_rect_intp_sfifo;
  localparam int W  = 28;
  localparam int D  = 2;
  localparam int DD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rect_intp_sfifo_if #(.W(W), .D(D)) if_a ();
  rect_intp_sfifo_if #(.W(W), .D(D)) if_b ();

  rect_intp_sfifo #(.W(W), .D(D), .FWFT(1'b1), .AF_LVL(3), .AE_LVL(1)) u_fwft (
    .clk (clk), .rst (rst), .f (if_a.slave)
  );
  rect_intp_sfifo #(.W(W), .D(D), .FWFT(1'b0), .AF_LVL(3), .AE_LVL(1)) u_reg (
    .clk (clk), .rst (rst), .f (if_b.slave)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference state
  logic [W-1:0] q[$];
  logic         m_ovf = 1'b0, m_udf = 1'b0;
  logic [W-1:0] m_rdout = '0;
  logic         m_rvld = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic w, input logic [W-1:0] d,
                       input logic rd, input logic clr);
    logic rd_ok, wr_ok;
    logic [W-1:0] v;
    if (r) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_rdout = '0; m_rvld = 1'b0;
      return;
    end
    rd_ok = rd && (q.size() > 0);
    wr_ok = w && ((q.size() < DD) || rd_ok);
    m_rvld = rd_ok;
    if (rd_ok) begin
      v = q.pop_front();
      m_rdout = v;
    end
    if (wr_ok) q.push_back(d);
    if (w && !wr_ok) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (rd && !rd_ok) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
  endtask

  task automatic check_all();
    int n;
    logic [W-1:0] head;
    n = q.size();
    head = (n > 0) ? q[0] : '0;
    chk("count",    32'(if_a.count),        32'(n));
    chk("count_r",  32'(if_b.count),        32'(n));
    chk("empty",    32'(if_a.empty),        32'(n == 0));
    chk("full",     32'(if_a.full),         32'(n == DD));
    chk("afull",    32'(if_a.almost_full),  32'(n >= 3));
    chk("aempty",   32'(if_a.almost_empty), 32'(n <= 1));
    chk("ovf",      32'(if_a.ovf),          32'(m_ovf));
    chk("udf",      32'(if_a.udf),          32'(m_udf));
    chk("fwft_dout", 32'(if_a.fifo_dout),   32'(head));
    chk("fwft_vld", 32'(if_a.dout_vld),     32'(n > 0));
    chk("reg_dout", 32'(if_b.fifo_dout),    32'(m_rdout));
    chk("reg_vld",  32'(if_b.dout_vld),     32'(m_rvld));
    chk("reg_ovf",  32'(if_b.ovf),          32'(m_ovf));
    chk("reg_udf",  32'(if_b.udf),          32'(m_udf));
  endtask

  task automatic step(input logic r, input logic w, input logic [W-1:0] d,
                      input logic rd, input logic clr);
    @(negedge clk);
    rst = r;
    if_a.fifo_wr = w;  if_a.fifo_din = d;  if_a.fifo_rd = rd;  if_a.err_clr = clr;
    if_b.fifo_wr = w;  if_b.fifo_din = d;  if_b.fifo_rd = rd;  if_b.err_clr = clr;
    @(posedge clk);
    model(r, w, d, rd, clr);
    #1 check_all();
  endtask

  initial begin
    logic [W-1:0] dat;
    if_a.fifo_wr = 1'b0; if_a.fifo_din = '0; if_a.fifo_rd = 1'b0; if_a.err_clr = 1'b0;
    if_b.fifo_wr = 1'b0; if_b.fifo_din = '0; if_b.fifo_rd = 1'b0; if_b.err_clr = 1'b0;

    // Reset then idle
    step(1, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);

    // Fill 1..4, overflow with 5, clear, drain
    for (int i = 1; i <= 4; i++) step(0, 1, W'(i), 0, 0);
    step(0, 1, 28'h0000005, 0, 0);
    step(0, 0, '0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 0);

    // Full with simultaneous read/write across the pointer wrap
    for (int i = 0; i < 4; i++) step(0, 1, W'(16 + i), 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, W'(32 + i), 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 0);

    // Read from empty with concurrent write, then clear
    step(0, 1, 28'hABCDEF0, 1, 0);
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 1, 0);

    // Registered-read sequence
    step(0, 1, 28'h1234567, 0, 0);
    step(0, 1, 28'h7654321, 0, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);

    // Reset mid-stream with a concurrent write
    for (int i = 0; i < 3; i++) step(0, 1, W'(64 + i), 0, 0);
    step(1, 1, 28'h0FFFFFF, 0, 1);
    step(0, 0, '0, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      dat = W'($urandom);
      step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), dat,
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rect_intp_sfifo.md
# rect_intp_sfifo

Parametrised synchronous FIFO that buffers interpolation coefficient/pixel words between the rectification address generator and the bilinear interpolator. It generalises the earlier fixed pointer-pair buffer. It adds full/empty/level flags, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error bits. The read mode is selectable at elaboration: first-word-fall-through or registered-read. One instance sits per interpolation lane, and the lane count is set by the parent.

## Interface
Parameters:
- W, 28, data word width in bits
- D, 2, log2 of depth; DD = 2^D entries (D ≥ 1)
- FWFT, 1, 1 = first-word-fall-through, 0 = registered read with dout_vld
- AF_LVL, DD-1, almost_full asserts when count ≥ AF_LVL
- AE_LVL, 1, almost_empty asserts when count ≤ AE_LVL

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous active-high reset
- fifo_wr  in  1  write request
- fifo_din  in  W  write data
- fifo_rd  in  1  read request (pop)
- fifo_dout  out  W  read data
- dout_vld  out  1  fifo_dout valid (FWFT: equals ~empty; mode 0: one-cycle pulse)
- full  out  1  count == DD
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LVL
- almost_empty  out  1  count ≤ AE_LVL
- count  out  D+1  current occupancy, 0..DD
- err_clr  in  1  clears ovf/udf
- ovf  out  1  sticky: write rejected
- udf  out  1  sticky: read rejected

## Operation
- Pointers: wr_ptr and rd_ptr are D bits wide, start at 0 and wrap modulo DD.
- Occupancy: count is D+1 bits and is the only source for every flag.
- Read acceptance: rd_acc = fifo_rd & ~empty.
- Write acceptance: wr_acc = fifo_wr & (~full | rd_acc). A write while full is accepted only together with an accepted read.
- Count update: count += wr_acc − rd_acc. With both accepted, count is unchanged and both pointers advance.
- Rejected write: the data is dropped, wr_ptr holds, and ovf sets.
- Rejected read: rd_ptr holds, and udf sets.
- Error bits: ovf and udf stay set until err_clr or rst. If err_clr and a new error occur in the same cycle, the error wins and the bit stays 1.
- FWFT=1:
  - fifo_dout = store[rd_ptr] when ~empty, else all-zero.
  - dout_vld = ~empty.
  - fifo_rd consumes the word currently shown.
- FWFT=0:
  - On rd_acc, store[rd_ptr] is registered into fifo_dout and dout_vld pulses high for one cycle.
  - Otherwise fifo_dout holds its last value and dout_vld = 0.
- Storage is not reset. Contents are don't-care until written.

## Timing
- Reset values: count=0, empty=1, full=0, almost_empty=1 (for AE_LVL ≥ 0), almost_full=0 (for AF_LVL ≥ 1), ovf=0, udf=0, dout_vld=0, fifo_dout=0, pointers 0.
- rst overrides every concurrent fifo_wr, fifo_rd and err_clr. A reset mid-stream discards all entries in one cycle.
- Write latency: a write at edge t updates flags and count after edge t. In FWFT the word is visible on fifo_dout in cycle t+1.
- Mode 0 read latency: rd_acc at edge t gives data and dout_vld after edge t (one cycle after request).
- Flags are registered-equivalent (derived from registered count). There is no combinational path from fifo_wr or fifo_rd to full, empty or count.
- FWFT fifo_dout is combinational from the registered pointer and array only, not from fifo_rd.
- Write to empty with simultaneous fifo_rd: the read is rejected, udf sets, and the write is stored.

## Structure
- Shared package rect_intp_pkg holds the default W/D constants and a function for the clog2/count width.
- Sub-module rect_intp_sfifo_ram is a DD×W register array with one write port and one asynchronous read port (no reset).
- The top module holds pointers, count, flags, error bits and the mode-0 output register, with the mode chosen by a generate on FWFT.

## Test plan
- Reset then idle, W=28, D=2: count=0, empty=1, full=0, almost_empty=1, ovf=udf=0, fifo_dout=0.
- Write 0x0000001..0x0000004 on consecutive cycles (FWFT=1):
  - full=1 and count=4 after the 4th write; almost_full=1 from count=3.
  - Fifth write 0x0000005 is rejected with ovf=1.
  - Four reads return 1,2,3,4 in order.
- Fill to 4, then assert fifo_wr and fifo_rd together for 6 cycles with incrementing data:
  - count stays 4, no ovf.
  - Output sequence continues without gaps across the pointer wrap.
- Read from empty with a simultaneous write of 0xABCDEF0:
  - udf=1, count=1, dout shows 0xABCDEF0 the next cycle.
  - err_clr on the following cycle clears udf.
- FWFT=0: write 0x1234567 then 0x7654321, pulse fifo_rd twice:
  - dout_vld pulses one cycle after each request.
  - fifo_dout=0x1234567, then 0x7654321, and holds afterward.
- Assert rst with count=3 while fifo_wr=1: all outputs return to reset values next cycle, and the write is not stored (count=0).
